// File: rtl/ram_cmd_pkg.sv
// Shared definitions for the RAM command master: opcodes, FSM states and command-word packing.
// Also intended for import by the RAM slave and its bench.
package ram_cmd_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned CmdWidth  = DataWidth + 2;

  localparam logic [1:0] OpWrAddr = 2'b00;
  localparam logic [1:0] OpWrData = 2'b01;
  localparam logic [1:0] OpRdAddr = 2'b10;
  localparam logic [1:0] OpRdData = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdCmd,
    StRdWait,
    StResp
  } state_e;

  function automatic logic [CmdWidth-1:0] cmd_word(input logic [1:0]           op,
                                                   input logic [DataWidth-1:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/ram_cmd_timer.sv
// Read-wait timeout counter: cleared before each wait, counts idle wait cycles and flags
// the last permitted one. Saturates instead of wrapping.
module ram_cmd_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TIMEOUT - 1);
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(TIMEOUT);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count equals the number of wait cycles already spent, so LastCnt marks the final one.
  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/ram_cmd_master.sv
// Host-side master that turns single read/write requests into the RAM's two-word
// command sequence and returns one response pulse per request.
module ram_cmd_master
  import ram_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DataWidth-1:0]  req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DataWidth-1:0]  rsp_rdata_o,
  output logic                  rsp_timeout_o,
  output logic [CmdWidth-1:0]   din_o,
  output logic                  rx_valid_o,
  input  logic [DataWidth-1:0]  dout_i,
  input  logic                  tx_valid_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  timeout_q, timeout_d;
  logic                  tmr_clear, tmr_enable, tmr_expired;

  ram_cmd_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;
    req_ready_o = 1'b0;
    rx_valid_o  = 1'b0;
    din_o       = '0;
    rsp_valid_o = 1'b0;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          write_d   = req_write_i;
          rdata_d   = '0;
          timeout_d = 1'b0;
          state_d   = req_write_i ? StWrAddr : StRdAddr;
        end
      end
      StWrAddr: begin
        rx_valid_o = 1'b1;
        din_o      = cmd_word(OpWrAddr, DataWidth'(addr_q));
        state_d    = StWrData;
      end
      StWrData: begin
        rx_valid_o = 1'b1;
        din_o      = cmd_word(OpWrData, wdata_q);
        state_d    = StResp;
      end
      StRdAddr: begin
        rx_valid_o = 1'b1;
        din_o      = cmd_word(OpRdAddr, DataWidth'(addr_q));
        state_d    = StRdCmd;
      end
      StRdCmd: begin
        rx_valid_o = 1'b1;
        din_o      = cmd_word(OpRdData, '0);
        tmr_clear  = 1'b1;
        state_d    = StRdWait;
      end
      StRdWait: begin
        // Data arriving on the expiry cycle still counts as a successful read.
        if (tx_valid_i) begin
          rdata_d = dout_i;
          state_d = StResp;
        end else if (tmr_expired) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_rdata_o   = write_q ? '0 : rdata_q;
  assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master: the bench plays the RAM from its own memory array.
module tb_ram_cmd_master;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_write;
  logic [7:0] req_addr, req_wdata, dout;
  logic       tx_valid;
  logic       req_ready, rsp_valid, rsp_timeout, rx_valid;
  logic [7:0] rsp_rdata;
  logic [9:0] din;

  logic [7:0] mem [256];
  int n_run  = 0;
  int n_fail = 0;

  ram_cmd_master #(
    .ADDR_WIDTH(8),
    .TIMEOUT   (T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_timeout_o(rsp_timeout),
    .din_o        (din),
    .rx_valid_o   (rx_valid),
    .dout_i       (dout),
    .tx_valid_i   (tx_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {req_ready, rx_valid, din, rsp_valid};
  endfunction

  // One request from an IDLE negedge; ends at the negedge of the following IDLE cycle.
  // n = RD_WAIT cycle carrying tx_valid (outside 1..T means never, i.e. timeout).
  task automatic run_txn(input string name, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input int n, input bit noise);
    logic [12:0] exp_v;
    logic [8:0]  exp_r;
    logic [7:0]  rd;
    bit          to;
    int          waits;
    n_run++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s idle-before: ready,rsp_valid got %b want 10", name, {req_ready, rsp_valid});
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    tx_valid = noise; dout = 8'hEE;
    @(negedge clk);
    req_valid = 1'b0;
    exp_v = {1'b0, 1'b1, (wr ? 2'b00 : 2'b10), addr, 1'b0};
    n_run++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL %s cmd1: got %h want %h", name, obs(), exp_v);
    end
    @(negedge clk);
    exp_v = {1'b0, 1'b1, (wr ? {2'b01, wdata} : 10'h300), 1'b0};
    n_run++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL %s cmd2: got %h want %h", name, obs(), exp_v);
    end
    if (wr) begin
      mem[addr] = wdata;
      exp_r = 9'h000;
    end else begin
      rd    = mem[addr];
      to    = (n < 1) || (n > T);
      waits = to ? T : n;
      for (int k = 1; k <= waits; k++) begin
        @(negedge clk);
        n_run++;
        if (obs() !== 13'h0) begin
          n_fail++;
          $display("FAIL %s wait%0d: got %h want 0000", name, k, obs());
        end
        tx_valid = (k == n);
        dout     = (k == n) ? rd : ~rd;
      end
      exp_r = to ? 9'h100 : {1'b0, rd};
    end
    @(negedge clk);
    tx_valid = noise; dout = 8'hEE;
    n_run++;
    if (obs() !== 13'h0001) begin
      n_fail++;
      $display("FAIL %s resp: got %h want 0001", name, obs());
    end
    n_run++;
    if ({rsp_timeout, rsp_rdata} !== exp_r) begin
      n_fail++;
      $display("FAIL %s rsp-data: timeout,rdata got %h want %h", name, {rsp_timeout, rsp_rdata},
               exp_r);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    n_run++;
    if (obs() !== 13'h1000) begin
      n_fail++;
      $display("FAIL %s idle-after: got %h want 1000", name, obs());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    tx_valid = 1'b0; dout = '0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({rx_valid, din, rsp_valid, rsp_timeout, rsp_rdata} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset-outputs: got %h want 0", {rx_valid, din, rsp_valid, rsp_timeout,
               rsp_rdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (obs() !== 13'h1000) begin
      n_fail++;
      $display("FAIL reset-release: got %h want 1000", obs());
    end
  endtask

  task automatic test_write();
    run_txn("write_3C_A5", 1'b1, 8'h3C, 8'hA5, 0, 1'b0);
  endtask

  task automatic test_write_read();
    run_txn("read_3C", 1'b0, 8'h3C, 8'h00, 1, 1'b0);
    run_txn("read_3C_n4", 1'b0, 8'h3C, 8'h11, 4, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout_never", 1'b0, 8'h3C, 8'h00, 0, 1'b0);
    run_txn("timeout_late", 1'b0, 8'h3C, 8'h00, T + 1, 1'b1);
  endtask

  task automatic test_last_cycle();
    run_txn("write_77_5A", 1'b1, 8'h77, 8'h5A, 0, 1'b0);
    run_txn("read_last_cycle", 1'b0, 8'h77, 8'h00, T, 1'b0);
    run_txn("read_penultimate", 1'b0, 8'h77, 8'h00, T - 1, 1'b0);
  endtask

  task automatic test_ignore_tx();
    run_txn("noise_write", 1'b1, 8'h01, 8'h96, 0, 1'b1);
    run_txn("noise_read", 1'b0, 8'h01, 8'h00, 2, 1'b1);
    run_txn("noise_read_n7", 1'b0, 8'h77, 8'h00, 7, 1'b1);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h3C; req_wdata = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if ({rx_valid, din} !== 11'h577) begin
      n_fail++;
      $display("FAIL midreset-wrdata: got %h want 577", {rx_valid, din});
    end
    #1 rst_n = 1'b0;
    #1;
    n_run++;
    if ({rx_valid, din, rsp_valid} !== 12'h0) begin
      n_fail++;
      $display("FAIL midreset-async: got %h want 000", {rx_valid, din, rsp_valid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_run++;
      if (obs() !== 13'h1000) begin
        n_fail++;
        $display("FAIL midreset-after%0d: got %h want 1000", i, obs());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_seq [8];
    exp_seq[0] = {2'b01, 10'h010, 1'b0};
    exp_seq[1] = {2'b01, 10'h1C3, 1'b0};
    exp_seq[2] = 13'h0001;
    exp_seq[3] = 13'h1000;
    exp_seq[4] = {2'b01, 10'h210, 1'b0};
    exp_seq[5] = {2'b01, 10'h300, 1'b0};
    exp_seq[6] = 13'h0000;
    exp_seq[7] = 13'h0001;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hC3;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_run++;
      if (obs() !== exp_seq[c]) begin
        n_fail++;
        $display("FAIL b2b-cyc%0d: got %h want %h", c + 1, obs(), exp_seq[c]);
      end
      if (c == 0) begin
        req_write = 1'b0;
        req_wdata = 8'h00;
      end
      if (c == 4) req_valid = 1'b0;
      tx_valid = (c == 6);
      dout     = (c == 6) ? 8'hC3 : 8'h00;
    end
    mem[8'h10] = 8'hC3;
    n_run++;
    if ({rsp_timeout, rsp_rdata} !== 9'h0C3) begin
      n_fail++;
      $display("FAIL b2b-rdata: got %h want 0C3", {rsp_timeout, rsp_rdata});
    end
    @(negedge clk);
    tx_valid = 1'b0;
    n_run++;
    if (obs() !== 13'h1000) begin
      n_fail++;
      $display("FAIL b2b-idle: got %h want 1000", obs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_txn("random", 1'($urandom_range(0, 1)), {4'hA, 4'($urandom_range(0, 15))},
              8'($urandom), int'($urandom_range(0, T + 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_write();
    test_write_read();
    test_timeout();
    test_last_cycle();
    test_ignore_tx();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_cmd_master.md
RAM_CMD_MASTER -- requirements
Module: ram_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning RAM address width; it SHALL equal data width 8.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max cycles to wait for tx_valid after a read-data command.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  master idle and able to accept a request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  8  target address.
REQ-009 req_wdata  input  8  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle pulse: request completed.
REQ-011 rsp_rdata  output  8  read data; valid with rsp_valid on reads, 0 on writes.
REQ-012 rsp_timeout  output  1  qualifies rsp_valid: read got no tx_valid within TIMEOUT.
REQ-013 din  output  10  RAM command word: [9:8] opcode, [7:0] payload.
REQ-014 rx_valid  output  1  din valid this cycle.
REQ-015 dout  input  8  RAM read data.
REQ-016 tx_valid  input  1  dout valid this cycle.

Function
REQ-017 Opcodes SHALL be 2'b00 write address, 2'b01 write data, 2'b10 read address, 2'b11 read data.
REQ-018 Request SHALL be accepted on a rising edge where req_valid && req_ready; req_addr, req_wdata, req_write SHALL be registered then.
REQ-019 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RESP.
REQ-020 IDLE: req_ready=1; on accept -> WR_ADDR if write else RD_ADDR.
REQ-021 WR_ADDR: rx_valid=1, din={00,addr}, one cycle -> WR_DATA.
REQ-022 WR_DATA: rx_valid=1, din={01,wdata}, one cycle -> RESP.
REQ-023 RD_ADDR: rx_valid=1, din={10,addr}, one cycle -> RD_CMD.
REQ-024 RD_CMD: rx_valid=1, din={11,8'h00}, one cycle -> RD_WAIT; timeout counter cleared.
REQ-025 RD_WAIT: rx_valid=0; on tx_valid capture dout into rsp_rdata -> RESP; else counter increments; when counter reaches TIMEOUT-1 without tx_valid -> RESP with rsp_timeout=1, rsp_rdata=0.
REQ-026 RESP: rsp_valid=1 for exactly one cycle -> IDLE; rsp_timeout is 0 unless set per REQ-025.
REQ-027 Write latency accept-to-rsp_valid SHALL be 3 cycles; read latency SHALL be 3 + N cycles where N (1..TIMEOUT) is the RD_WAIT cycle in which tx_valid arrives.
REQ-028 tx_valid outside RD_WAIT SHALL be ignored; tx_valid in the same cycle as timeout expiry SHALL win (data captured, rsp_timeout=0).
REQ-029 rx_valid SHALL be 0 and din SHALL be 0 in IDLE, RD_WAIT and RESP.
REQ-030 req_ready SHALL be 0 in every state except IDLE; no request queuing.
REQ-031 Timeout counter width SHALL be $clog2(TIMEOUT+1) and SHALL not wrap.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, counter 0, din 0, rx_valid 0, rsp_valid 0, rsp_rdata 0, rsp_timeout 0, registered request 0; req_ready SHALL read 1 once reset deasserts.
REQ-033 Reset mid-transaction SHALL abort it with no rsp_valid pulse.

Structure
REQ-034 Opcode constants and FSM state enum SHALL live in a shared package ram_cmd_pkg, also imported by the RAM and its bench.
REQ-035 A sub-module ram_cmd_timer (clear, enable, expired) SHALL be natural for the RD_WAIT counter; otherwise flat.

Verification
REQ-036 Write req addr=8'h3C data=8'hA5 -> din 10'h03C then 10'h1A5 on consecutive cycles with rx_valid=1, rsp_valid 3 cycles after accept.
REQ-037 Write then read addr=8'h3C against the RAM -> din 10'h23C, 10'h300, rsp_rdata=8'hA5, rsp_timeout=0.
REQ-038 Read with tx_valid held low -> rsp_valid with rsp_timeout=1, rsp_rdata=0, exactly TIMEOUT cycles after RD_CMD.
REQ-039 tx_valid asserted on the final RD_WAIT cycle with dout=8'h5A -> rsp_rdata=8'h5A, rsp_timeout=0.
REQ-040 rst_n pulsed low during WR_DATA -> rx_valid=0 immediately, no rsp_valid, req_ready=1 after release.
REQ-041 req_valid held high across back-to-back requests -> second accepted only on the cycle after RESP; 1000 random requests vs golden RAM model with zero mismatches.
